pipeline_stall_controller: RTL and testbench

Central hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the enable, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits.
- Detects data-memory timeouts.
- Keeps a stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 166 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central hazard/stall sequencer for the 5-stage MIPS pipeline. Produces the
// enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Handles load-use hazards, taken-branch squashes and multi-cycle data-memory
// waits, detects data-memory timeouts, and counts stall cycles.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        ID instruction actually reads rt
//   ex_MemRead, ex_rt EX instruction is a load, and its destination register
//   ex_branch_taken   branch resolved taken in EX
//   mem_req/mem_ready MEM-stage data memory access and its completion
//   *_en              per-stage register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   if_id_flush       load NOP into IF/ID
//   id_ex_flush       load bubble into ID/EX
//   mem_wb_bubble     suppress RegWrite/MemToReg on MEM/WB capture
//   mem_timeout       sticky data-memory timeout flag
//   stall_cycles      saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]       stall_q, stall_d;

    logic mstall;
    logic lu;

    assign mstall = mem_req & ~mem_ready;
    assign lu     = ex_MemRead & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // Controls are combinational; rst forces everything quiet regardless
    // of the (possibly stale) registered state.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        if (rst) begin
            // all quiet
        end else if (state_q == ERROR) begin
            mem_wb_bubble = 1'b1;
            mem_timeout   = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (mstall) begin
                // Freeze upstream; MEM/WB keeps moving but captures a bubble
                // so the stalled access never writes back twice.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                // ID instruction is squashed, so any load-use is moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID one cycle, drop a bubble into EX.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mstall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mstall) begin
                    if (wait_cnt_q + 1'b1 == TMO) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Counter saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_MemRead, ex_branch_taken, mem_req, mem_ready;

    // DUT a: MEM_TIMEOUT=8, DUT b: MEM_TIMEOUT=4; both see the same inputs.
    logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_bub, a_tmo;
    logic [15:0] a_stall;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_bub, b_tmo;
    logic [15:0] b_stall;

    logic [4:0]  en_a, en_b;
    logic [2:0]  ctl_a, ctl_b;

    int checks = 0;
    int errors = 0;

    assign en_a  = {a_pc, a_ifid, a_idex, a_exmem, a_memwb};
    assign en_b  = {b_pc, b_ifid, b_idex, b_exmem, b_memwb};
    assign ctl_a = {a_iff, a_idf, a_bub};
    assign ctl_b = {b_iff, b_idf, b_bub};

    pipeline_stall_controller #(.MEM_TIMEOUT(8), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
        .mem_wb_en(a_memwb), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .mem_wb_bubble(a_bub), .mem_timeout(a_tmo), .stall_cycles(a_stall)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
        .mem_wb_en(b_memwb), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .mem_wb_bubble(b_bub), .mem_timeout(b_tmo), .stall_cycles(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_MemRead = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) tick();
        checks++; if (en_a !== 5'b00000) begin errors++; $display("FAIL rst_en_a: got %b exp %b", en_a, 5'b00000); end
        checks++; if (ctl_a !== 3'b000) begin errors++; $display("FAIL rst_ctl_a: got %b exp %b", ctl_a, 3'b000); end
        checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL rst_stall_a: got %0d exp 0", a_stall); end
        checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL rst_tmo_a: got %b exp 0", a_tmo); end
        checks++; if (en_b !== 5'b00000) begin errors++; $display("FAIL rst_en_b: got %b exp %b", en_b, 5'b00000); end
        rst = 1'b0; idle();
        #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL rel_en_a: got %b exp %b", en_a, 5'b11111); end
        checks++; if (ctl_a !== 3'b000) begin errors++; $display("FAIL rel_ctl_a: got %b exp %b", ctl_a, 3'b000); end
        tick();
        checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL rel_stall_a: got %0d exp 0", a_stall); end
    endtask

    task automatic test_load_use();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        checks++; if (en_a !== 5'b00111) begin errors++; $display("FAIL lu_en: got %b exp %b", en_a, 5'b00111); end
        checks++; if (ctl_a !== 3'b010) begin errors++; $display("FAIL lu_ctl: got %b exp %b", ctl_a, 3'b010); end
        tick();
        idle(); #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL lu_after_en: got %b exp %b", en_a, 5'b11111); end
        checks++; if (a_stall !== 16'd1) begin errors++; $display("FAIL lu_stall: got %0d exp 1", a_stall); end
        tick();
        // r0 destination never creates a hazard
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL lu_r0_en: got %b exp %b", en_a, 5'b11111); end
        tick();
        // rt match only counts when ID reads rt
        ex_MemRead = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        #1;
        checks++; if (en_a !== 5'b00111) begin errors++; $display("FAIL lu_rt_en: got %b exp %b", en_a, 5'b00111); end
        tick();
        id_uses_rt = 1'b0; #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL lu_nort_en: got %b exp %b", en_a, 5'b11111); end
        checks++; if (a_stall !== 16'd2) begin errors++; $display("FAIL lu_rt_stall: got %0d exp 2", a_stall); end
        tick();
        idle();
    endtask

    task automatic test_branch_vs_lu();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
        #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL br_en: got %b exp %b", en_a, 5'b11111); end
        checks++; if (ctl_a !== 3'b110) begin errors++; $display("FAIL br_ctl: got %b exp %b", ctl_a, 3'b110); end
        tick();
        idle(); #1;
        checks++; if (a_stall !== 16'd2) begin errors++; $display("FAIL br_stall: got %0d exp 2", a_stall); end
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (en_a !== 5'b00001) begin errors++; $display("FAIL mw_en[%0d]: got %b exp %b", i, en_a, 5'b00001); end
            checks++; if (ctl_a !== 3'b001) begin errors++; $display("FAIL mw_ctl[%0d]: got %b exp %b", i, ctl_a, 3'b001); end
            tick();
        end
        mem_ready = 1'b1; #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL mw_done_en: got %b exp %b", en_a, 5'b11111); end
        checks++; if (ctl_a !== 3'b000) begin errors++; $display("FAIL mw_done_ctl: got %b exp %b", ctl_a, 3'b000); end
        checks++; if (a_stall !== 16'd5) begin errors++; $display("FAIL mw_stall: got %0d exp 5", a_stall); end
        tick();
        idle();
    endtask

    task automatic test_simultaneous();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        checks++; if (en_a !== 5'b00001) begin errors++; $display("FAIL sim_en: got %b exp %b", en_a, 5'b00001); end
        checks++; if (ctl_a !== 3'b001) begin errors++; $display("FAIL sim_ctl: got %b exp %b", ctl_a, 3'b001); end
        tick();
        // mem_req dropping ends the wait
        idle(); #1;
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL sim_drop_en: got %b exp %b", en_a, 5'b11111); end
        tick();
        checks++; if (a_stall !== 16'd6) begin errors++; $display("FAIL sim_stall: got %0d exp 6", a_stall); end
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (en_b !== 5'b00001 || b_tmo !== 1'b0) begin errors++; $display("FAIL to_wait[%0d]: got en=%b tmo=%b exp en=00001 tmo=0", i, en_b, b_tmo); end
            tick();
        end
        checks++; if (b_tmo !== 1'b1) begin errors++; $display("FAIL to_flag: got %b exp 1", b_tmo); end
        checks++; if (en_b !== 5'b00000 || ctl_b !== 3'b001) begin errors++; $display("FAIL to_ctl: got en=%b ctl=%b exp en=00000 ctl=001", en_b, ctl_b); end
        checks++; if (a_tmo !== 1'b0) begin errors++; $display("FAIL to_a_notmo: got %b exp 0", a_tmo); end
        checks++; if (b_stall !== 16'd10) begin errors++; $display("FAIL to_stall_b: got %0d exp 10", b_stall); end
        mem_ready = 1'b1; #1;
        checks++; if (b_tmo !== 1'b1 || en_b !== 5'b00000) begin errors++; $display("FAIL to_sticky: got tmo=%b en=%b exp tmo=1 en=00000", b_tmo, en_b); end
        checks++; if (en_a !== 5'b11111) begin errors++; $display("FAIL to_a_ready: got %b exp %b", en_a, 5'b11111); end
        tick();
        idle(); #1;
        checks++; if (b_stall !== 16'd11 || a_stall !== 16'd10) begin errors++; $display("FAIL to_stall_ab: got b=%0d a=%0d exp b=11 a=10", b_stall, a_stall); end
    endtask

    task automatic test_saturation();
        repeat (70000) tick();
        checks++; if (b_stall !== 16'hFFFF) begin errors++; $display("FAIL sat_b: got %h exp ffff", b_stall); end
        checks++; if (a_stall !== 16'd10) begin errors++; $display("FAIL sat_a: got %0d exp 10", a_stall); end
        checks++; if (b_tmo !== 1'b1) begin errors++; $display("FAIL sat_tmo: got %b exp 1", b_tmo); end
    endtask

    task automatic test_reset_recover();
        // put a into MEM_WAIT, then reset both mid-wait / in ERROR
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1; tick();
        rst = 1'b0; idle(); #1;
        checks++; if (b_tmo !== 1'b0 || b_stall !== 16'd0) begin errors++; $display("FAIL rr_b: got tmo=%b stall=%0d exp tmo=0 stall=0", b_tmo, b_stall); end
        checks++; if (en_b !== 5'b11111 || en_a !== 5'b11111) begin errors++; $display("FAIL rr_en: got a=%b b=%b exp 11111", en_a, en_b); end
        checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL rr_a_stall: got %0d exp 0", a_stall); end
        // a must restart its wait count from zero: 7 stalls, still no timeout
        mem_req = 1'b1;
        repeat (7) tick();
        checks++; if (a_tmo !== 1'b0 || en_a !== 5'b00001) begin errors++; $display("FAIL rr_a_wait: got tmo=%b en=%b exp tmo=0 en=00001", a_tmo, en_a); end
        tick();
        checks++; if (a_tmo !== 1'b1) begin errors++; $display("FAIL rr_a_tmo: got %b exp 1", a_tmo); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_mem_wait();
        test_simultaneous();
        test_timeout();
        test_saturation();
        test_reset_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
